// File: rtl/kv_transit_pkg.sv
// Shared definitions for the key/value transit front and back ends:
// beat-0 header layout, header struct and the transit FSM state set.
package kv_transit_pkg;

    localparam logic [15:0] HDR_MAGIC      = 16'hFFFF;
    localparam int          KVT_META_W     = 64;
    localparam int          HDR_OFF_MAGIC  = 0;
    localparam int          HDR_OFF_FIELDS = 32;
    localparam int          HDR_OFF_KEY    = 128;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_VAL     = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Packed MSB-first so it drops straight into beat-0 bits [127:32].
    typedef struct packed {
        logic [KVT_META_W-1:0] meta;
        logic [7:0]            opcode;
        logic [7:0]            keylen;
        logic [15:0]           totlen;
    } hdr_t;

    localparam int HDR_W = $bits(hdr_t);

    function automatic logic [6:0] keep_popcount(input logic [63:0] keep);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + {6'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-entry AXI-Stream output register; payload holds steady while stalled.
module axis_out_reg #(
    parameter int DATA_W = 512,
    parameter int KEEP_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_tdata,
    output logic [KEEP_W-1:0] o_tkeep,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              i_tready
);

    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;
    logic              r_valid;

    assign o_ready  = !r_valid || i_tready;
    assign o_tdata  = r_data;
    assign o_tkeep  = r_keep;
    assign o_tlast  = r_last;
    assign o_tvalid = r_valid;

    // Load a new beat only when the slot is empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
                r_keep <= i_keep;
                r_last <= i_last;
            end
        end
    end

endmodule

// File: rtl/back_end_transit.sv
// Serialises a response descriptor plus value beats into AXI-Stream packets
// and returns the value-buffer pointer once the packet has left.
module back_end_transit
    import kv_transit_pkg::*;
#(
    parameter int DATA_W        = 512,
    parameter int KEEP_W        = 64,
    parameter int META_W        = 64,
    parameter int PTR_W         = 16,
    parameter int MAX_KEY_WORDS = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_hdr_opcode,
    input  logic [META_W-1:0]             s_hdr_meta,
    input  logic [7:0]                    s_hdr_keylen_words,
    input  logic [15:0]                   s_hdr_vallen_words,
    input  logic [DATA_W-HDR_OFF_KEY-1:0] s_hdr_key,
    input  logic [PTR_W-1:0]              s_hdr_ptr,
    input  logic                          s_hdr_valid,
    output logic                          s_hdr_ready,
    input  logic [DATA_W-1:0]             s_value_data,
    input  logic [KEEP_W-1:0]             s_value_keep,
    input  logic                          s_value_last,
    input  logic                          s_value_valid,
    output logic                          s_value_ready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [KEEP_W-1:0]             m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PTR_W-1:0]              m_free_pointer,
    output logic                          m_free_pointer_valid,
    input  logic                          m_free_pointer_ready,
    output logic                          err_drop,
    output logic                          err_len
);

    localparam logic [7:0] MAX_KEY_W8 = 8'(MAX_KEY_WORDS);

    state_e            r_state, w_state_nxt;
    logic              r_active;
    logic [PTR_W-1:0]  r_ptr;
    logic [15:0]       r_vallen;
    logic [16:0]       r_wcnt, w_wcnt_nxt;
    logic              r_wait_last, r_err_drop, r_err_len;
    logic              w_can_load, w_key_ok, w_hdr_rdy, w_val_rdy, w_free_valid;
    logic              w_hdr_fire, w_val_fire;
    logic              w_out_valid, w_out_last;
    logic [DATA_W-1:0] w_out_data, w_beat0;
    logic [KEEP_W-1:0] w_out_keep;
    logic [6:0]        w_beat_words;
    logic [17:0]       w_wsum;
    hdr_t              w_hdr;

    assign w_key_ok   = (s_hdr_keylen_words <= MAX_KEY_W8);
    assign w_hdr_fire = s_hdr_valid && w_hdr_rdy;
    assign w_val_fire = s_value_valid && w_val_rdy;

    assign s_hdr_ready          = w_hdr_rdy;
    assign s_value_ready        = w_val_rdy;
    assign m_free_pointer       = r_ptr;
    assign m_free_pointer_valid = w_free_valid;
    assign err_drop             = r_err_drop;
    assign err_len              = r_err_len;

    // Beat-0 image and the saturating value-word count.
    always_comb begin
        w_hdr.meta   = s_hdr_meta;
        w_hdr.opcode = s_hdr_opcode;
        w_hdr.keylen = s_hdr_keylen_words;
        w_hdr.totlen = {8'd0, s_hdr_keylen_words} + s_hdr_vallen_words;
        w_beat0 = '0;
        w_beat0[HDR_OFF_MAGIC +: 16]                   = HDR_MAGIC;
        w_beat0[HDR_OFF_FIELDS +: HDR_W]               = w_hdr;
        w_beat0[HDR_OFF_KEY +: DATA_W - HDR_OFF_KEY]   = s_hdr_key;
        w_beat_words = keep_popcount(s_value_keep) >> 2;
        w_wsum       = {1'b0, r_wcnt} + {11'd0, w_beat_words};
        w_wcnt_nxt   = w_wsum[17] ? 17'h1FFFF : w_wsum[16:0];
    end

    // Next state, handshake readies and output-register load request.
    always_comb begin
        w_state_nxt  = r_state;
        w_hdr_rdy    = 1'b0;
        w_val_rdy    = 1'b0;
        w_free_valid = 1'b0;
        w_out_valid  = 1'b0;
        w_out_data   = w_beat0;
        w_out_keep   = '1;
        w_out_last   = (s_hdr_vallen_words == 16'd0);
        case (r_state)
            ST_IDLE: begin
                w_hdr_rdy = r_active && w_can_load;
                if (s_hdr_valid && w_hdr_rdy) begin
                    w_out_valid = w_key_ok;
                    if (s_hdr_vallen_words == 16'd0) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_state_nxt = w_key_ok ? ST_VAL : ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VAL: begin
                w_val_rdy   = w_can_load && !r_wait_last;
                w_out_valid = s_value_valid && w_val_rdy;
                w_out_data  = s_value_data;
                w_out_keep  = s_value_keep;
                w_out_last  = s_value_last;
                if (r_wait_last && m_axis_tvalid && m_axis_tready) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_VAL;
                end
            end
            ST_DRAIN: begin
                w_val_rdy = 1'b1;
                if (s_value_valid && s_value_last) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_RELEASE: begin
                // A header-only packet may still be sitting in the output register.
                w_free_valid = !m_axis_tvalid;
                if (w_free_valid && m_free_pointer_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; descriptor intake is held off for one cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
        end
    end

    // Per-packet context, word counting and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_vallen    <= 16'd0;
            r_wcnt      <= 17'd0;
            r_wait_last <= 1'b0;
            r_err_drop  <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_drop <= w_hdr_fire && !w_key_ok;
            r_err_len  <= 1'b0;
            if (w_hdr_fire) begin
                r_ptr       <= s_hdr_ptr;
                r_vallen    <= s_hdr_vallen_words;
                r_wcnt      <= 17'd0;
                r_wait_last <= 1'b0;
            end else if (r_state == ST_VAL && w_val_fire) begin
                r_wcnt <= w_wcnt_nxt;
                if (s_value_last) begin
                    r_wait_last <= 1'b1;
                    r_err_len   <= (w_wcnt_nxt != {1'b0, r_vallen});
                end
            end
        end
    end

    axis_out_reg #(
        .DATA_W (DATA_W),
        .KEEP_W (KEEP_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (w_out_data),
        .i_keep   (w_out_keep),
        .i_last   (w_out_last),
        .i_valid  (w_out_valid),
        .o_ready  (w_can_load),
        .o_tdata  (m_axis_tdata),
        .o_tkeep  (m_axis_tkeep),
        .o_tlast  (m_axis_tlast),
        .o_tvalid (m_axis_tvalid),
        .i_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_back_end_transit.sv
// Scoreboard bench for back_end_transit: the driver pushes expected beats,
// pointers and error counts; a negedge monitor pops and compares.
module tb_back_end_transit;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    logic         clk, rst_n;
    logic [7:0]   s_hdr_opcode, s_hdr_keylen_words;
    logic [63:0]  s_hdr_meta;
    logic [15:0]  s_hdr_vallen_words, s_hdr_ptr;
    logic [383:0] s_hdr_key;
    logic         s_hdr_valid, s_hdr_ready;
    logic [511:0] s_value_data;
    logic [63:0]  s_value_keep;
    logic         s_value_last, s_value_valid, s_value_ready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [15:0]  m_free_pointer;
    logic         m_free_pointer_valid, m_free_pointer_ready;
    logic         err_drop, err_len;

    beat_t        exp_beats[$];
    logic [15:0]  exp_ptrs[$];
    int           exp_drop = 0, exp_len = 0, obs_drop = 0, obs_len = 0;
    int           total = 0, bad = 0, n_timeout = 0;
    int           tr_mode = 0, free_stall_len = 0;
    bit           main_done = 0;
    bit           prev_stall = 0;
    beat_t        prev_beat;

    back_end_transit dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_hdr_opcode         (s_hdr_opcode),
        .s_hdr_meta           (s_hdr_meta),
        .s_hdr_keylen_words   (s_hdr_keylen_words),
        .s_hdr_vallen_words   (s_hdr_vallen_words),
        .s_hdr_key            (s_hdr_key),
        .s_hdr_ptr            (s_hdr_ptr),
        .s_hdr_valid          (s_hdr_valid),
        .s_hdr_ready          (s_hdr_ready),
        .s_value_data         (s_value_data),
        .s_value_keep         (s_value_keep),
        .s_value_last         (s_value_last),
        .s_value_valid        (s_value_valid),
        .s_value_ready        (s_value_ready),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tkeep         (m_axis_tkeep),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_free_pointer       (m_free_pointer),
        .m_free_pointer_valid (m_free_pointer_valid),
        .m_free_pointer_ready (m_free_pointer_ready),
        .err_drop             (err_drop),
        .err_len              (err_len)
    );

    initial begin
        clk = 1'b0;
        forever #2 clk = ~clk;
    end

    // Downstream ready pattern: 0 = always, 1 = toggling, 2 = random.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tr_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Pool ready: held low for free_stall_len cycles after each release starts.
    initial begin
        int  cnt;
        bit  pv;
        cnt = 0;
        pv  = 1'b0;
        m_free_pointer_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (m_free_pointer_valid && !pv) cnt = free_stall_len;
            pv = m_free_pointer_valid;
            if (m_free_pointer_valid && cnt > 0) begin
                m_free_pointer_ready = 1'b0;
                cnt--;
            end else begin
                m_free_pointer_ready = 1'b1;
            end
        end
    end

    function automatic void chk(input bit ok, input string nm,
                                input logic [639:0] act, input logic [639:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    task automatic sample();
        beat_t        e;
        logic [15:0]  p;
        logic [598:0] all_out;
        if (!rst_n) begin
            all_out = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid, m_free_pointer,
                       m_free_pointer_valid, s_hdr_ready, s_value_ready, err_drop, err_len};
            chk(all_out == '0, "reset_zero", 640'(all_out), 640'd0);
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall)
            chk(m_axis_tvalid && {m_axis_tdata, m_axis_tkeep, m_axis_tlast} == prev_beat,
                "stall_hold", 640'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 640'(prev_beat));
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_beats.size() == 0) begin
                chk(1'b0, "unexpected_beat", 640'(m_axis_tdata), 640'd0);
            end else begin
                e = exp_beats.pop_front();
                chk(m_axis_tdata == e.data, "beat_data", 640'(m_axis_tdata), 640'(e.data));
                chk(m_axis_tkeep == e.keep, "beat_keep", 640'(m_axis_tkeep), 640'(e.keep));
                chk(m_axis_tlast == e.last, "beat_last", 640'(m_axis_tlast), 640'(e.last));
            end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (m_free_pointer_valid && m_free_pointer_ready) begin
            if (exp_ptrs.size() == 0) begin
                chk(1'b0, "unexpected_ptr", 640'(m_free_pointer), 640'd0);
            end else begin
                p = exp_ptrs.pop_front();
                chk(m_free_pointer == p, "free_ptr", 640'(m_free_pointer), 640'(p));
            end
        end
        if (m_free_pointer_valid && !m_free_pointer_ready)
            chk(!s_hdr_ready, "hdr_ready_in_release", 640'(s_hdr_ready), 640'd0);
        if (err_drop) obs_drop++;
        if (err_len)  obs_len++;
    endtask

    // Monitor / scoreboard: all comparisons and the summary happen here.
    initial begin
        while (!main_done) begin
            @(negedge clk);
            sample();
        end
        for (int i = 0; i < 500 && (exp_beats.size() != 0 || exp_ptrs.size() != 0); i++) begin
            @(negedge clk);
            sample();
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample();
        end
        chk(exp_beats.size() == 0, "beats_left", 640'(exp_beats.size()), 640'd0);
        chk(exp_ptrs.size() == 0, "ptrs_left", 640'(exp_ptrs.size()), 640'd0);
        chk(obs_drop == exp_drop, "err_drop_count", 640'(obs_drop), 640'(exp_drop));
        chk(obs_len == exp_len, "err_len_count", 640'(obs_len), 640'(exp_len));
        chk(n_timeout == 0, "handshake_timeouts", 640'(n_timeout), 640'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic hs_hdr();
        int n;
        n = 0;
        s_hdr_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_hdr_ready) break;
            n++;
            if (n > 2000) begin
                n_timeout++;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_hdr_valid = 1'b0;
    endtask

    task automatic hs_val();
        int n;
        n = 0;
        s_value_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_value_ready) break;
            n++;
            if (n > 2000) begin
                n_timeout++;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_value_valid = 1'b0;
    endtask

    // Issue one descriptor and act_words words of value; max_beats < 0 means all
    // beats and a pointer release, otherwise the packet is cut short (reset test).
    task automatic run_pkt(input logic [7:0] op, input logic [7:0] kl, input logic [15:0] vl,
                           input logic [63:0] meta, input int act_words, input int max_beats);
        beat_t        b;
        logic [383:0] key;
        logic [15:0]  ptr;
        logic [511:0] d;
        logic [63:0]  kp;
        int           rem, w, nb;
        bit           ok;
        ok  = (kl <= 8'd12);
        ptr = 16'($urandom);
        for (int i = 0; i < 12; i++) key[i*32 +: 32] = $urandom;
        s_hdr_opcode       = op;
        s_hdr_keylen_words = kl;
        s_hdr_vallen_words = vl;
        s_hdr_meta         = meta;
        s_hdr_key          = key;
        s_hdr_ptr          = ptr;
        if (max_beats < 0) exp_ptrs.push_back(ptr);
        if (ok) begin
            b.data           = '0;
            b.data[15:0]     = 16'hFFFF;
            b.data[47:32]    = 16'((int'(kl) + int'(vl)) % 65536);
            b.data[55:48]    = kl;
            b.data[63:56]    = op;
            b.data[127:64]   = meta;
            b.data[511:128]  = key;
            b.keep           = '1;
            b.last           = (vl == 16'd0);
            exp_beats.push_back(b);
        end else begin
            exp_drop++;
        end
        hs_hdr();
        if (vl != 16'd0) begin
            rem = act_words;
            nb  = 0;
            while (rem > 0 && (max_beats < 0 || nb < max_beats)) begin
                w   = (rem > 16) ? 16 : rem;
                kp  = (w == 16) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (4 * w)) - 64'd1);
                rem = rem - w;
                for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
                s_value_data = d;
                s_value_keep = kp;
                s_value_last = (rem == 0);
                if (ok) begin
                    b.data = d;
                    b.keep = kp;
                    b.last = (rem == 0);
                    exp_beats.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                hs_val();
                nb++;
            end
            if (ok && max_beats < 0 && act_words != int'(vl)) exp_len++;
        end
    endtask

    // Directed cases followed by randomized traffic.
    initial begin
        logic [7:0]  kl;
        logic [15:0] vl;
        int          act, n;
        rst_n = 1'b0;
        s_hdr_valid = 1'b0;
        s_value_valid = 1'b0;
        s_hdr_opcode = 8'd0;
        s_hdr_keylen_words = 8'd0;
        s_hdr_vallen_words = 16'd0;
        s_hdr_meta = 64'd0;
        s_hdr_key = '0;
        s_hdr_ptr = 16'd0;
        s_value_data = '0;
        s_value_keep = '0;
        s_value_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        tr_mode = 0;
        free_stall_len = 0;
        run_pkt(8'h01, 8'd8, 16'd104, 64'h0000_FFFF_FFFF_0000, 104, -1);
        run_pkt(8'h02, 8'd4, 16'd0, 64'h1234_5678_9ABC_DEF0, 0, -1);
        run_pkt(8'h03, 8'd13, 16'd16, 64'hDEAD_BEEF_0000_0001, 16, -1);
        tr_mode = 1;
        free_stall_len = 5;
        run_pkt(8'h01, 8'd8, 16'd104, 64'h0000_FFFF_FFFF_0000, 104, -1);
        tr_mode = 0;
        free_stall_len = 0;
        run_pkt(8'h05, 8'd2, 16'd32, 64'hA5A5_A5A5_5A5A_5A5A, 16, -1);
        run_pkt(8'h06, 8'd12, 16'd4, 64'h0F0F_0F0F_F0F0_F0F0, 4, -1);
        run_pkt(8'h07, 8'd8, 16'hFFF9, 64'h1111_2222_3333_4444, 16, -1);
        run_pkt(8'h08, 8'd20, 16'd0, 64'h5555_6666_7777_8888, 0, -1);

        run_pkt(8'h01, 8'd8, 16'd104, 64'h0000_FFFF_FFFF_0000, 104, 2);
        n = 0;
        while (exp_beats.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_beats.size() != 0) n_timeout++;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_pkt(8'h09, 8'd8, 16'd20, 64'h0000_FFFF_FFFF_0000, 20, -1);

        for (int i = 0; i < 25; i++) begin
            tr_mode        = $urandom_range(0, 2);
            free_stall_len = $urandom_range(0, 3);
            kl  = 8'($urandom_range(0, 14));
            vl  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 48));
            act = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 48)) : int'(vl);
            run_pkt(8'($urandom), kl, vl, {$urandom, $urandom}, act, -1);
        end
        main_done = 1'b1;
    end

endmodule
